// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W    = 24;
  localparam int DEF_DATA_W    = 24;
  localparam int DEF_MEM_DEPTH = 271;

  // Sequencer states: pick a winner, run one memory cycle, acknowledge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester id: 0 = processor load/store, 1 = image DMA/loader.
  typedef logic req_id_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the two requesters.
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// without it, r0 has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic    i_req0,
  input  logic    i_req1,
  input  req_id_t i_ptr,
  output logic    o_gnt_vld,
  output req_id_t o_gnt_id
);

  assign o_gnt_vld = i_req0 | i_req1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Tie goes to whichever requester was not granted last.
  always_comb begin
    o_gnt_id = 1'b0;
    if (i_req0 && i_req1) o_gnt_id = ~i_ptr;
    else                  o_gnt_id = i_req1;
  end
`else
  // The pointer is not needed in fixed-priority mode.
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;

  // r0 wins every tie; r1 only wins when r0 is idle.
  always_comb begin
    o_gnt_id = 1'b0;
    o_gnt_id = ~i_req0 & i_req1;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-port data memory.
// Each access takes three cycles: IDLE (arbitrate) -> ACCESS (strobe) -> RESP (ack).
// Build option: DMEM_ARB_ROUND_ROBIN_EN (handled inside dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  state_t            r_state;
  req_id_t           r_ptr;
  req_id_t           r_id;
  logic              r_err;
  logic              r_mem_write;
  logic              r_mem_read;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_gnt_vld;
  req_id_t           w_gnt_id;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_err;
  logic [DATA_W-1:0] w_cap;

  dmem_arb_pick u_pick (
    .i_req0    (r0_req),
    .i_req1    (r1_req),
    .i_ptr     (r_ptr),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  assign w_sel_we    = w_gnt_id ? r1_we    : r0_we;
  assign w_sel_addr  = w_gnt_id ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_gnt_id ? r1_wdata : r0_wdata;
  assign w_sel_err   = (w_sel_addr >= DEPTH_A);

  // Only a real read strobe returns memory data; writes and rejected accesses return 0.
  assign w_cap = r_mem_read ? mem_rdata : '0;

  // Sequencer: latch the winner, strobe memory for one cycle, then pulse its ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b1;
      r_id        <= 1'b0;
      r_err       <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_id        <= w_gnt_id;
            r_ptr       <= w_gnt_id;
            r_err       <= w_sel_err;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_write <= w_sel_we & ~w_sel_err;
            r_mem_read  <= ~w_sel_we & ~w_sel_err;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          if (r_id == 1'b0) begin
            r_ack0   <= 1'b1;
            r_err0   <= r_err;
            r_rdata0 <= w_cap;
          end else begin
            r_ack1   <= 1'b1;
            r_err1   <= r_err;
            r_rdata1 <= w_cap;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_write = r_mem_write;
  assign mem_read  = r_mem_read;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // A reset landing in the RESP cycle must hide the ack already on the wire.
  assign r0_ack   = r_ack0 & ~reset;
  assign r1_ack   = r_ack1 & ~reset;
  assign r0_err   = r_err0 & ~reset;
  assign r1_err   = r_err1 & ~reset;
  assign r0_rdata = r_rdata0;
  assign r1_rdata = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [23:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [23:0] r0_rdata, r1_rdata;
  logic        mem_write, mem_read;
  logic [23:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous write, combinational read. The undriven bus is
  // modelled as a junk pattern so any capture outside a real read is visible.
  logic [23:0] mem [0:270];
  always @(posedge clk)
    if (mem_write && mem_addr < 24'd271) mem[mem_addr[8:0]] <= mem_wdata;
  assign mem_rdata = (mem_read && mem_addr < 24'd271) ? mem[mem_addr[8:0]] : 24'h5A5A5A;

  // Strobe activity counters, sampled at the edge closing each cycle.
  always @(posedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit p, input bit we, input logic [23:0] a, input logic [23:0] d);
    if (p) begin r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; end
    else   begin r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; end
  endtask

  task automatic drop(input bit p);
    if (p) r1_req = 1'b0; else r0_req = 1'b0;
  endtask

  // Issue one access from a negedge in IDLE; returns at the negedge showing ack.
  task automatic access(input bit p, input bit we, input logic [23:0] a, input logic [23:0] d,
                        output int lat, output logic e, output logic [23:0] rd, output bit other);
    bit got = 0;
    lat = 99; e = 1'bx; rd = 'x; other = 0;
    drive(p, we, a, d);
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (p ? r0_ack : r1_ack) other = 1;
      if (p ? r1_ack : r0_ack) begin
        got = 1; lat = k;
        e  = p ? r1_err : r0_err;
        rd = p ? r1_rdata : r0_rdata;
      end
    end
    drop(p);
  endtask

  typedef struct {
    bit          p;
    bit          we;
    logic [23:0] a;
    logic [23:0] d;
    bit          e;
    logic [23:0] rd;
  } vec_t;

  vec_t tv[10];

  // Tie from IDLE: r0 reads addr 1, r1 reads addr 2; winner acks at 2, loser at 5.
  task automatic tie(input bit first, input string tag);
    int t0 = 99, t1 = 99;
    logic [23:0] v0 = 'x, v1 = 'x;
    drive(0, 0, 24'd1, 24'd0);
    drive(1, 0, 24'd2, 24'd0);
    for (int k = 1; k <= 10 && (t0 == 99 || t1 == 99); k++) begin
      @(negedge clk);
      if (r0_ack) begin t0 = k; v0 = r0_rdata; drop(0); end
      if (r1_ack) begin t1 = k; v1 = r1_rdata; drop(1); end
    end
    drop(0); drop(1);
    chk({tag, "_r0_lat"}, t0, first ? 5 : 2);
    chk({tag, "_r1_lat"}, t1, first ? 2 : 5);
    chk({tag, "_r0_rdata"}, v0, 24'h111111);
    chk({tag, "_r1_rdata"}, v1, 24'h222222);
    @(negedge clk);
  endtask

  initial begin
    int lat; logic e; logic [23:0] rd; bit other;
    int rd0, wr0, nacks;
    int t[4];
    reset = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_acks",    {r0_ack, r1_ack, r0_err, r1_err}, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_r0_rdata", r0_rdata, 0);
    chk("rst_r1_rdata", r1_rdata, 0);

    tv[0] = '{0, 1, 24'd5,   24'hABCDEF, 0, 24'h000000};
    tv[1] = '{0, 0, 24'd5,   24'h000000, 0, 24'hABCDEF};
    tv[2] = '{1, 1, 24'd1,   24'h111111, 0, 24'h000000};
    tv[3] = '{0, 1, 24'd2,   24'h222222, 0, 24'h000000};
    tv[4] = '{1, 0, 24'd1,   24'h000000, 0, 24'h111111};
    tv[5] = '{0, 1, 24'd270, 24'h765432, 0, 24'h000000};
    tv[6] = '{1, 0, 24'd270, 24'h000000, 0, 24'h765432};
    tv[7] = '{1, 0, 24'd271, 24'h000000, 1, 24'h000000};
    tv[8] = '{0, 1, 24'd300, 24'hFFFFFF, 1, 24'h000000};
    tv[9] = '{1, 0, 24'd2,   24'h000000, 0, 24'h222222};

    foreach (tv[i]) begin
      rd0 = rd_cnt; wr0 = wr_cnt;
      access(tv[i].p, tv[i].we, tv[i].a, tv[i].d, lat, e, rd, other);
      chk($sformatf("v%0d_lat", i), lat, 2);
      chk($sformatf("v%0d_err", i), e, tv[i].e);
      chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("v%0d_other_ack", i), other, 0);
      chk($sformatf("v%0d_wr_strobes", i), wr_cnt - wr0, (tv[i].we && !tv[i].e) ? 1 : 0);
      chk($sformatf("v%0d_rd_strobes", i), rd_cnt - rd0, (!tv[i].we && !tv[i].e) ? 1 : 0);
      @(negedge clk);
      chk($sformatf("v%0d_ack_pulse", i), tv[i].p ? r1_ack : r0_ack, 0);
      chk($sformatf("v%0d_rdata_hold", i), tv[i].p ? r1_rdata : r0_rdata, tv[i].rd);
    end

    // Arbitration: last grant r1 -> r0 wins; last grant r0 -> round-robin gives r1.
    access(1, 0, 24'd2, 24'd0, lat, e, rd, other);
    @(negedge clk);
    tie(0, "tieA");
    access(0, 0, 24'd1, 24'd0, lat, e, rd, other);
    @(negedge clk);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    tie(1, "tieB");
`else
    tie(0, "tieB");
`endif

    // Held request: four back-to-back writes, one access every three cycles.
    nacks = 0;
    foreach (t[i]) t[i] = 99;
    drive(0, 1, 24'd0, 24'hA00000);
    for (int k = 1; k <= 16 && nacks < 4; k++) begin
      @(negedge clk);
      if (r0_ack) begin
        t[nacks] = k;
        nacks++;
        if (nacks < 4) begin r0_addr = 24'(nacks); r0_wdata = 24'hA00000 + 24'(nacks); end
        else drop(0);
      end
    end
    drop(0);
    chk("b2b_ack0", t[0], 2);
    chk("b2b_ack1", t[1], 5);
    chk("b2b_ack2", t[2], 8);
    chk("b2b_ack3", t[3], 11);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      access(1, 0, 24'(i), 24'd0, lat, e, rd, other);
      chk($sformatf("b2b_rb%0d", i), rd, 24'hA00000 + 24'(i));
      @(negedge clk);
    end

    // Reset during the ACCESS cycle of an r1 write: write lands, no ack.
    drive(1, 1, 24'd7, 24'h000123);
    @(negedge clk);
    chk("rstacc_wstrobe", mem_write, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstacc_no_ack", {r0_ack, r1_ack}, 0);
    drop(1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstacc_quiet%0d", k), {r0_ack, r1_ack, mem_read, mem_write}, 0);
    end
    chk("rstacc_mem7", mem[7], 24'h000123);
    access(0, 0, 24'd7, 24'd0, lat, e, rd, other);
    chk("rstacc_lat", lat, 2);
    chk("rstacc_rb", rd, 24'h000123);
    @(negedge clk);

    // Reset during RESP hides the ack already presented.
    access(0, 0, 24'd5, 24'd0, lat, e, rd, other);
    chk("rstresp_lat", lat, 2);
    reset = 1'b1;
    #1;
    chk("rstresp_ack", r0_ack, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Idle: nothing requested, nothing happens.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", k), {r0_ack, r1_ack, mem_read, mem_write}, 0);
    end
    chk("never_both_strobes", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port data memory. It shares the memory between requester 0 (processor load/store path) and requester 1 (image DMA/loader), and drives the memory's `write`, `read`, `addr_in` and `data_in` controls. It captures the memory's combinational read data and returns it to the granted requester with a one-cycle acknowledge. It sits between the processor/DMA and the data memory. It owns all memory control signals; no other block drives them.

## Interface
- `ADDR_W`, 24, address width
- `DATA_W`, 24, data width
- `MEM_DEPTH`, 271, number of valid words; addresses >= `MEM_DEPTH` are rejected

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset: synchronous, active-high
- `r0_req`, `r1_req`  in  1  access request, held until ack
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read
- `r0_addr`, `r1_addr`  in  ADDR_W  word address
- `r0_wdata`, `r1_wdata`  in  DATA_W  write data
- `r0_ack`, `r1_ack`  out  1  one-cycle completion pulse
- `r0_err`, `r1_err`  out  1  valid with ack; address out of range
- `r0_rdata`, `r1_rdata`  out  DATA_W  read data, valid with ack, held until next ack to that port
- `mem_write`, `mem_read`  out  1  memory strobes
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data (combinational; high-Z when not reading)

## Operation
- States: `IDLE`, `ACCESS`, `RESP`.
- **IDLE:** if any `req` is high, pick a winner. Latch its `we`, `addr` and `wdata` plus a winner id. Set `err_q = (addr >= MEM_DEPTH)`. Go to `ACCESS`. Otherwise stay in `IDLE`.
- **ACCESS:** drive `mem_addr` and `mem_wdata` from the latched values.
  - If `err_q` is clear: `mem_write = we_q`, `mem_read = !we_q`.
  - If `err_q` is set: both strobes are 0.
  - At the closing edge, capture `mem_rdata` for a valid read. Capture 0 for a write or an error.
  - Go to `RESP`.
- **RESP:** pulse the winner's `ack` and present its `err`. Update that port's `rdata` register. Go to `IDLE`.
- The loser's request stays pending and is arbitrated on the next `IDLE` cycle.
- A requester holds `req` and its operands stable until ack. If a requester drops `req` early, the latched access still completes and still acks.
- Holding `req` high after ack starts a new access on the next `IDLE` cycle. Back-to-back throughput is 1 access per 3 cycles.
- `mem_read` and `mem_write` are never high together, and are both 0 outside `ACCESS`.

## Timing
- Reset values:
  - state is `IDLE`.
  - All acks, errs, strobes, `mem_addr`, `mem_wdata` and both `rdata` registers are 0.
  - The round-robin pointer selects r0.
- Latency: `req` high in cycle n while in `IDLE` → `ACCESS` in cycle n+1 → `ack` in cycle n+2.
- Write commit: the memory write takes effect at the edge ending the `ACCESS` cycle. A read issued afterwards sees the new value.
- Strobes and address are registered state decodes with no combinational path from `rN_req` to `mem_*`.
- Reset while in `ACCESS`: the write strobe was already high for that cycle, so the write commits. No ack is issued and the state returns to `IDLE`.
- Reset while in `RESP`: the ack is suppressed.
- Both `req` high in the same cycle: resolved per Configuration. Exactly one ack per access.
- Address `MEM_DEPTH - 1` is valid. Address `MEM_DEPTH` gets an error ack with `rdata = 0`.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit pointer records the last granted requester.
  - On a tie, the other requester wins.
  - The pointer updates on each grant; error grants count as grants.
- Not defined:
  - Fixed priority: r0 always wins ties.
  - r1 can starve under continuous r0 traffic; this is accepted.

## Structure
- Package `dmem_arb_pkg`:
  - the state enum (`IDLE`, `ACCESS`, `RESP`)
  - the requester id type (1 bit)
  - default `ADDR_W`, `DATA_W` and `MEM_DEPTH` constants
- Sub-module `dmem_arb_pick`:
  - inputs: two req bits and the pointer
  - outputs: grant valid and grant id
  - Holds the macro-dependent selection logic so the FSM is identical in both builds.

## Test plan
- r0 write addr 5 data 0xABCDEF, then r0 read addr 5 → ack cycles n+2, `r0_rdata` = 0xABCDEF, `r0_err` = 0.
- Both req in the same cycle, r0 read addr 1, r1 read addr 2 → r0 acked first, r1 acked 3 cycles later. With `_EN`, a second tie → r1 first.
- r1 read addr 271 → `r1_ack` with `r1_err` = 1, `r1_rdata` = 0, `mem_read` never asserted.
- r0 holds req for 4 writes to addr 0..3 → acks at cycles n+2, n+5, n+8, n+11; readback matches.
- Reset asserted during `ACCESS` of r1 write addr 7 data 0x000123 → no ack, state `IDLE`, memory[7] = 0x000123.
- Idle with no requests for 10 cycles → `mem_read` and `mem_write` stay 0, no acks.
